// File: rtl/icache_tag_if.sv
// Request/response and tag SRAM signals of the icache tag controller.
//
// Handshake: a transfer on lookup or fill happens in the cycle where both
// valid and ready are high. A requester may assert valid at any time. It
// must hold the payload stable while valid is high and ready is low. Ready
// never depends on valid. resp_valid is a single-cycle pulse with no ready.
interface icache_tag_if #(
  parameter int IDX_WIDTH = 4,
  parameter int TAG_WIDTH = 23
);
  logic                 lookup_valid;
  logic                 lookup_ready;
  logic [IDX_WIDTH-1:0] lookup_idx;
  logic [TAG_WIDTH-1:0] lookup_tag;
  logic                 resp_valid;
  logic                 resp_hit;
  logic                 fill_valid;
  logic                 fill_ready;
  logic [IDX_WIDTH-1:0] fill_idx;
  logic [TAG_WIDTH-1:0] fill_tag;
  logic                 flush_req;
  logic                 flush_busy;
  logic                 tag_csb0;
  logic                 tag_web0;
  logic [IDX_WIDTH-1:0] tag_addr0;
  logic [TAG_WIDTH:0]   tag_din0;
  logic                 tag_csb1;
  logic [IDX_WIDTH-1:0] tag_addr1;
  logic [TAG_WIDTH:0]   tag_dout1;
  logic                 state_dbg;  // 0 = FLUSH, 1 = IDLE

  modport slave (
    input  lookup_valid, lookup_idx, lookup_tag,
    input  fill_valid, fill_idx, fill_tag, flush_req, tag_dout1,
    output lookup_ready, resp_valid, resp_hit, fill_ready, flush_busy,
    output tag_csb0, tag_web0, tag_addr0, tag_din0, tag_csb1, tag_addr1,
    output state_dbg
  );

  modport master (
    output lookup_valid, lookup_idx, lookup_tag,
    output fill_valid, fill_idx, fill_tag, flush_req, tag_dout1,
    input  lookup_ready, resp_valid, resp_hit, fill_ready, flush_busy,
    input  tag_csb0, tag_web0, tag_addr0, tag_din0, tag_csb1, tag_addr1,
    input  state_dbg
  );
endinterface

// File: rtl/icache_tag_ctrl.sv
// Icache tag SRAM sequencer and port arbiter. After reset, and on request,
// it sweeps every entry to invalid. Fills are written on port 0 and lookups
// are read on port 1. A fill is forwarded to a lookup of the same index in
// the same cycle, because the SRAM commits that write one edge too late for
// the read.
module icache_tag_ctrl #(
  parameter int IDX_WIDTH = 4,
  parameter int TAG_WIDTH = 23
) (
  input logic         clk,
  input logic         rst,
  icache_tag_if.slave bus
);
  localparam int DW = TAG_WIDTH + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] flush_idx_q, flush_idx_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [TAG_WIDTH-1:0] req_tag_q, req_tag_d;
  logic                 byp_q, byp_d;
  logic [TAG_WIDTH-1:0] byp_tag_q, byp_tag_d;
  logic                 lookup_acc;
  logic                 fill_acc;
  logic [DW-1:0]        dout_eff;

  // Next state, port arbitration and SRAM command generation.
  always_comb begin
    state_d           = state_q;
    flush_idx_d       = flush_idx_q;
    lookup_acc        = 1'b0;
    fill_acc          = 1'b0;
    bus.lookup_ready  = 1'b0;
    bus.fill_ready    = 1'b0;
    bus.flush_busy    = 1'b1;
    bus.tag_csb0      = 1'b1;
    bus.tag_web0      = 1'b1;
    bus.tag_addr0     = '0;
    bus.tag_din0      = '0;
    bus.tag_csb1      = 1'b1;
    bus.tag_addr1     = '0;
    case (state_q)
      ST_FLUSH: begin
        // Reset holds the state here, so port 0 is gated off while rst is high.
        if (!rst) begin
          bus.tag_csb0  = 1'b0;
          bus.tag_web0  = 1'b0;
          bus.tag_addr0 = flush_idx_q;
          flush_idx_d   = flush_idx_q + 1'b1;
          if (flush_idx_q == LAST_IDX) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        bus.flush_busy   = 1'b0;
        bus.lookup_ready = 1'b1;
        // A fill racing a flush would be wiped anyway; refusing it keeps
        // port 0 free for the first sweep write.
        bus.fill_ready   = !bus.flush_req;
        lookup_acc       = bus.lookup_valid;
        fill_acc         = bus.fill_valid && !bus.flush_req;
        if (fill_acc) begin
          bus.tag_csb0  = 1'b0;
          bus.tag_web0  = 1'b0;
          bus.tag_addr0 = bus.fill_idx;
          bus.tag_din0  = {1'b1, bus.fill_tag};
        end
        if (lookup_acc) begin
          bus.tag_csb1  = 1'b0;
          bus.tag_addr1 = bus.lookup_idx;
        end
        if (bus.flush_req) begin
          state_d     = ST_FLUSH;
          flush_idx_d = '0;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
    resp_valid_d = lookup_acc;
    req_tag_d    = lookup_acc ? bus.lookup_tag : req_tag_q;
    byp_d        = lookup_acc && fill_acc && (bus.fill_idx == bus.lookup_idx);
    byp_tag_d    = fill_acc ? bus.fill_tag : byp_tag_q;
  end

  // State and response pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FLUSH;
      flush_idx_q  <= '0;
      resp_valid_q <= 1'b0;
      req_tag_q    <= '0;
      byp_q        <= 1'b0;
      byp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      flush_idx_q  <= flush_idx_d;
      resp_valid_q <= resp_valid_d;
      req_tag_q    <= req_tag_d;
      byp_q        <= byp_d;
      byp_tag_q    <= byp_tag_d;
    end
  end

  assign dout_eff       = byp_q ? {1'b1, byp_tag_q} : bus.tag_dout1;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_valid_q && dout_eff[DW-1] &&
                          (dout_eff[TAG_WIDTH-1:0] == req_tag_q);
  assign bus.state_dbg  = (state_q == ST_IDLE);
endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Testbench for icache_tag_ctrl with a behavioural dual-port tag SRAM.
module tb_icache_tag_ctrl;
  localparam int IW = 4;
  localparam int TW = 23;
  localparam int DW = TW + 1;
  localparam int NE = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  icache_tag_if #(.IDX_WIDTH(IW), .TAG_WIDTH(TW)) bus ();

  icache_tag_ctrl #(.IDX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- SRAM model ----------------
  // Port 0: captured at edge N, committed at edge N+1. Port 1: address
  // captured at edge N, data visible during cycle N+1.
  logic          preload = 1'b1;
  logic [DW-1:0] mem [NE];
  logic          p0_pend = 1'b0;
  logic [IW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_din  = '0;
  logic [IW-1:0] p1_addr = '0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NE; i++) mem[i] <= '1;
    end else if (p0_pend) begin
      mem[p0_addr] <= p0_din;
    end
    p0_pend <= !bus.tag_csb0 && !bus.tag_web0;
    p0_addr <= bus.tag_addr0;
    p0_din  <= bus.tag_din0;
    if (!bus.tag_csb1) p1_addr <= bus.tag_addr1;
  end
  assign bus.tag_dout1 = mem[p1_addr];

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [0:0]    exp_q[$];
  logic          prev_acc = 1'b0;
  int            n_resp   = 0;
  logic          m_valid [NE];
  logic [TW-1:0] m_tag   [NE];

  initial for (int i = 0; i < NE; i++) begin
    m_valid[i] = 1'b0;
    m_tag[i]   = '0;
  end

  always @(negedge clk) begin : sb
    logic lacc;
    logic facc;
    logic hit;
    chk("sb_resp_valid", bus.resp_valid, rst ? 1'b0 : prev_acc);
    if (bus.resp_valid) begin
      n_resp++;
      if (exp_q.size() > 0) chk("sb_resp_hit", bus.resp_hit, exp_q.pop_front());
    end
    lacc = !rst && bus.lookup_valid && bus.lookup_ready;
    facc = !rst && bus.fill_valid && bus.fill_ready;
    if (lacc) begin
      if (facc && bus.fill_idx == bus.lookup_idx)
        hit = (bus.fill_tag == bus.lookup_tag);
      else
        hit = m_valid[bus.lookup_idx] && (m_tag[bus.lookup_idx] == bus.lookup_tag);
      exp_q.push_back(hit);
    end
    if (facc) begin
      m_valid[bus.fill_idx] = 1'b1;
      m_tag[bus.fill_idx]   = bus.fill_tag;
    end
    if (rst || bus.flush_req) for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    if (rst) exp_q.delete();
    prev_acc = lacc;
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.lookup_valid = 1'b0;
    bus.lookup_idx   = '0;
    bus.lookup_tag   = '0;
    bus.fill_valid   = 1'b0;
    bus.fill_idx     = '0;
    bus.fill_tag     = '0;
    bus.flush_req    = 1'b0;
  endtask

  typedef struct {
    logic          fv;
    logic [IW-1:0] fi;
    logic [TW-1:0] ft;
    logic          lv;
    logic [IW-1:0] li;
    logic [TW-1:0] lt;
    logic          rv;
    logic          hit;
  } vec_t;

  function automatic vec_t mk(input logic fv, input logic [IW-1:0] fi, input logic [TW-1:0] ft,
                              input logic lv, input logic [IW-1:0] li, input logic [TW-1:0] lt,
                              input logic rv, input logic hit);
    vec_t v;
    v.fv = fv; v.fi = fi; v.ft = ft; v.lv = lv; v.li = li; v.lt = lt; v.rv = rv; v.hit = hit;
    return v;
  endfunction

  function automatic logic [TW-1:0] pool(input logic [IW-1:0] idx, input int sel);
    return TW'(sel * 256 + int'(idx));
  endfunction

  // Watchdog: the stimulus is bounded, this only guards against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequences ----------------
  initial begin
    vec_t vecs[9];
    int   resp_base;
    // Response in row k belongs to the lookup issued in row k-1.
    vecs[0] = mk(1, 5, 23'h12345, 0, 0, 23'h0,     0, 0);
    vecs[1] = mk(0, 0, 23'h0,     1, 5, 23'h12345, 0, 0);
    vecs[2] = mk(0, 0, 23'h0,     1, 5, 23'h12346, 1, 1);
    vecs[3] = mk(1, 9, 23'h7ABCD, 1, 9, 23'h7ABCD, 1, 0);
    vecs[4] = mk(1, 9, 23'h11111, 1, 8, 23'h7ABCD, 1, 1);
    vecs[5] = mk(0, 0, 23'h0,     1, 9, 23'h11111, 1, 0);
    vecs[6] = mk(0, 0, 23'h0,     1, 9, 23'h7ABCD, 1, 1);
    vecs[7] = mk(0, 0, 23'h0,     0, 0, 23'h0,     1, 0);
    vecs[8] = mk(0, 0, 23'h0,     0, 0, 23'h0,     0, 0);

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    smp();
    chk("rst_flush_busy", bus.flush_busy, 1);
    chk("rst_lookup_ready", bus.lookup_ready, 0);
    chk("rst_fill_ready", bus.fill_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_hit", bus.resp_hit, 0);
    chk("rst_csb0", bus.tag_csb0, 1);
    chk("rst_web0", bus.tag_web0, 1);
    chk("rst_csb1", bus.tag_csb1, 1);
    chk("rst_addr0", bus.tag_addr0, 0);
    chk("rst_din0", bus.tag_din0, 0);
    chk("rst_addr1", bus.tag_addr1, 0);

    // Test 1: initial sweep with a lookup held pending; SRAM preloaded with all ones.
    nxt();
    preload          = 1'b0;
    rst              = 1'b0;
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = 4'd3;
    bus.lookup_tag   = '1;
    for (int i = 0; i < NE; i++) begin
      smp();
      chk("t1_flush_busy", bus.flush_busy, 1);
      chk("t1_lookup_ready", bus.lookup_ready, 0);
      chk("t1_csb0", bus.tag_csb0, 0);
      chk("t1_web0", bus.tag_web0, 0);
      chk("t1_addr0", bus.tag_addr0, i);
      chk("t1_din0", bus.tag_din0, 0);
      nxt();
    end
    smp();
    chk("t1_idle_busy", bus.flush_busy, 0);
    chk("t1_idle_lookup_ready", bus.lookup_ready, 1);
    chk("t1_csb1", bus.tag_csb1, 0);
    chk("t1_addr1", bus.tag_addr1, 3);
    nxt();
    bus.lookup_valid = 1'b0;
    smp();
    chk("t1_resp_valid", bus.resp_valid, 1);
    chk("t1_resp_hit", bus.resp_hit, 0);
    nxt();

    // Tests 2 and 3: fill-then-lookup, same-cycle bypass, different index.
    for (int k = 0; k < 9; k++) begin
      bus.fill_valid   = vecs[k].fv;
      bus.fill_idx     = vecs[k].fi;
      bus.fill_tag     = vecs[k].ft;
      bus.lookup_valid = vecs[k].lv;
      bus.lookup_idx   = vecs[k].li;
      bus.lookup_tag   = vecs[k].lt;
      smp();
      chk("tv_lookup_ready", bus.lookup_ready, 1);
      chk("tv_fill_ready", bus.fill_ready, 1);
      chk("tv_csb0", bus.tag_csb0, !vecs[k].fv);
      if (vecs[k].fv) begin
        chk("tv_web0", bus.tag_web0, 0);
        chk("tv_addr0", bus.tag_addr0, vecs[k].fi);
        chk("tv_din0", bus.tag_din0, {1'b1, vecs[k].ft});
      end
      chk("tv_csb1", bus.tag_csb1, !vecs[k].lv);
      if (vecs[k].lv) chk("tv_addr1", bus.tag_addr1, vecs[k].li);
      chk("tv_resp_valid", bus.resp_valid, vecs[k].rv);
      if (vecs[k].rv) chk("tv_resp_hit", bus.resp_hit, vecs[k].hit);
      nxt();
    end

    // Test 4: populate every entry, flush with a racing fill and lookup.
    drive_idle();
    for (int i = 0; i < NE; i++) begin
      bus.fill_valid = 1'b1;
      bus.fill_idx   = IW'(i);
      bus.fill_tag   = pool(IW'(i), 1);
      nxt();
    end
    bus.fill_valid   = 1'b1;
    bus.fill_idx     = 4'd0;
    bus.fill_tag     = 23'h3FF;
    bus.flush_req    = 1'b1;
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = 4'd4;
    bus.lookup_tag   = pool(4'd4, 1);
    smp();
    chk("t4_fill_ready", bus.fill_ready, 0);
    chk("t4_lookup_ready", bus.lookup_ready, 1);
    chk("t4_csb0", bus.tag_csb0, 1);
    nxt();
    bus.lookup_valid = 1'b0;
    for (int i = 0; i < NE; i++) begin
      bus.flush_req = (i == 5);
      smp();
      chk("t4_flush_busy", bus.flush_busy, 1);
      chk("t4_fill_ready_busy", bus.fill_ready, 0);
      chk("t4_addr0", bus.tag_addr0, i);
      if (i == 0) begin
        chk("t4_preflush_valid", bus.resp_valid, 1);
        chk("t4_preflush_hit", bus.resp_hit, 1);
      end
      nxt();
    end
    bus.flush_req  = 1'b0;
    bus.fill_valid = 1'b0;
    smp();
    chk("t4_sweep_len", bus.flush_busy, 0);
    nxt();
    for (int i = 0; i < NE; i++) begin
      bus.lookup_valid = 1'b1;
      bus.lookup_idx   = IW'(i);
      bus.lookup_tag   = pool(IW'(i), 1);
      smp();
      if (i > 0) chk("t4_miss", bus.resp_hit, 0);
      nxt();
    end
    bus.lookup_valid = 1'b0;
    smp();
    chk("t4_miss_last", bus.resp_hit, 0);
    nxt();

    // Test 5: reset during a lookup response, then during a sweep.
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = 4'd2;
    nxt();
    bus.lookup_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_resp_valid", bus.resp_valid, 0);
    chk("t5_rst_csb1", bus.tag_csb1, 1);
    chk("t5_rst_busy", bus.flush_busy, 1);
    nxt();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      smp();
      chk("t5_pre_addr0", bus.tag_addr0, i);
      if (i < 7) nxt();
    end
    #1;
    rst = 1'b1;
    #1;
    chk("t5_mid_csb0", bus.tag_csb0, 1);
    chk("t5_mid_busy", bus.flush_busy, 1);
    chk("t5_mid_addr0", bus.tag_addr0, 0);
    nxt();
    nxt();
    rst = 1'b0;
    for (int i = 0; i < NE; i++) begin
      smp();
      chk("t5_busy", bus.flush_busy, 1);
      chk("t5_addr0", bus.tag_addr0, i);
      nxt();
    end
    smp();
    chk("t5_sweep_len", bus.flush_busy, 0);
    nxt();

    // Test 6: back-to-back lookups with random fills, checked by the scoreboard.
    resp_base = n_resp;
    for (int i = 0; i < 32; i++) begin
      bus.lookup_valid = 1'b1;
      bus.lookup_idx   = IW'($urandom_range(0, NE - 1));
      bus.lookup_tag   = pool(bus.lookup_idx, int'($urandom_range(0, 1)));
      bus.fill_valid   = 1'($urandom_range(0, 1));
      bus.fill_idx     = ($urandom_range(0, 2) == 0) ? bus.lookup_idx : IW'($urandom_range(0, NE - 1));
      bus.fill_tag     = pool(bus.fill_idx, int'($urandom_range(0, 1)));
      nxt();
    end
    drive_idle();
    smp();
    nxt();
    chk("t6_resp_count", n_resp - resp_base, 32);

    repeat (2) nxt();
    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_tag_ctrl.md
Name: icache_tag_ctrl

Overview:
- Sequencer and port arbiter for the 16-entry x 24-bit dual-port icache tag SRAM (port 0 RW, port 1 R).
- After reset, and on request, it sweeps all entries to invalid.
- It serves tag lookups on SRAM port 1 and fill writes on SRAM port 0.
- It forwards a same-cycle fill to a lookup on the same index, hiding the SRAM's one-cycle write commit delay.
- Sits between the icache front-end / miss handler and the tag SRAM instance.

Parameters:
- IDX_WIDTH, 4, set index width; number of entries is 2**IDX_WIDTH.
- TAG_WIDTH, 23, stored tag width; SRAM word = {valid, tag} = TAG_WIDTH+1 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- lookup_valid  in  1  lookup request.
- lookup_ready  out  1  lookup accepted when valid && ready.
- lookup_idx  in  IDX_WIDTH  set index.
- lookup_tag  in  TAG_WIDTH  tag to compare.
- resp_valid  out  1  lookup result valid.
- resp_hit  out  1  stored entry valid and tag equal.
- fill_valid  in  1  fill request.
- fill_ready  out  1  fill accepted when valid && ready.
- fill_idx  in  IDX_WIDTH  fill index.
- fill_tag  in  TAG_WIDTH  tag written with valid=1.
- flush_req  in  1  single-cycle pulse: invalidate all entries.
- flush_busy  out  1  sweep in progress.
- tag_csb0  out  1  SRAM port 0 chip select, active-low.
- tag_web0  out  1  SRAM port 0 write enable, active-low.
- tag_addr0  out  IDX_WIDTH  SRAM port 0 address.
- tag_din0  out  TAG_WIDTH+1  SRAM port 0 write data.
- tag_csb1  out  1  SRAM port 1 chip select, active-low.
- tag_addr1  out  IDX_WIDTH  SRAM port 1 address.
- tag_dout1  in  TAG_WIDTH+1  SRAM port 1 read data; bit MSB = valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- SRAM timing the block relies on:
  - Port 0 command presented in cycle N is captured at edge N and committed to the array at edge N+1.
  - Port 1 address presented in cycle N is captured at edge N; tag_dout1 is valid combinationally during cycle N+1.
- States:
  - FLUSH: sweep counter flush_idx (IDX_WIDTH bits).
  - IDLE.
- During rst:
  - State=FLUSH, flush_idx=0.
  - flush_busy=1, lookup_ready=0, fill_ready=0, resp_valid=0, resp_hit=0.
  - tag_csb0=1, tag_web0=1, tag_csb1=1.
  - addr/din outputs are 0.
- FLUSH:
  - Each cycle drives tag_csb0=0, tag_web0=0, tag_addr0=flush_idx, tag_din0=0, then increments flush_idx.
  - After the write of index 2**IDX_WIDTH-1, flush_idx wraps to 0 and the state goes to IDLE.
  - Sweep takes exactly 16 cycles (default).
  - flush_busy=1, lookup_ready=0, fill_ready=0.
  - flush_req during FLUSH is ignored; the sweep is not restarted.
- IDLE:
  - flush_busy=0, lookup_ready=1.
  - fill_ready = !flush_req.
  - flush_req=1 moves to FLUSH with flush_idx=0; the first sweep write is presented the following cycle.
- Fill:
  - When accepted, drives tag_csb0=0, tag_web0=0, tag_addr0=fill_idx, tag_din0={1'b1, fill_tag} in the same cycle (combinational).
  - Otherwise port 0 idles with tag_csb0=1, tag_web0=1.
- Lookup:
  - When accepted in cycle N: tag_csb1=0, tag_addr1=lookup_idx (combinational).
  - lookup_tag is registered.
  - resp_valid=1 in cycle N+1 only.
  - resp_hit = dout_eff[MSB] && (dout_eff[TAG_WIDTH-1:0] == registered tag).
  - Latency is 1 cycle; one lookup is accepted per cycle, back-to-back.
- Forwarding:
  - If a fill and a lookup are accepted in the same cycle with equal index, the block registers a bypass flag and the fill tag.
  - In that case, dout_eff in the response cycle = {1'b1, fill_tag}; otherwise dout_eff = tag_dout1.
  - A fill in cycle N-1 followed by a lookup in cycle N needs no bypass, because the SRAM has already committed the fill.
- flush_req in IDLE with a lookup the same cycle: the lookup is accepted and its response is produced from pre-flush contents.
- Lookups accepted in the cycle before FLUSH is entered still produce a response.
- rst asserted mid-sweep or mid-lookup:
  - Immediately clears resp_valid and all SRAM selects.
  - The sweep restarts from index 0 after release.

Test Plan:
1. Release reset; hold lookup_valid=1 -> flush_busy=1 and lookup_ready=0 for exactly 16 cycles with tag_addr0=0..15, tag_din0=0; then lookup of idx 3 gives resp_valid=1, resp_hit=0 one cycle later.
2. Fill idx 5, tag 0x12345 in cycle N; lookup idx 5, tag 0x12345 in cycle N+1 -> resp_hit=1 at N+2; lookup idx 5, tag 0x12346 -> resp_hit=0.
3. Same-cycle fill idx 9, tag 0x7ABCD and lookup idx 9, tag 0x7ABCD -> resp_hit=1 next cycle via bypass; same-cycle fill idx 9 with lookup idx 8 -> no bypass, resp_hit from SRAM (0 after flush).
4. Populate idx 0..15, pulse flush_req with fill_valid=1 -> fill_ready=0 that cycle, 16-cycle sweep; then all 16 lookups miss; flush_req pulsed mid-sweep does not extend it beyond 16 cycles.
5. Assert rst at sweep index 7 -> tag_csb0=1 and flush_busy=1 immediately; after release the sweep restarts at index 0 and lasts 16 cycles.
6. 32 back-to-back lookups with random fills -> one resp_valid per accepted lookup at exactly 1-cycle latency; resp_hit matches a scoreboard model.
